// File: rtl/serial_arith_pkg.sv
// Shared definitions for the digit-serial arithmetic unit.
//  - state_t : FSM state encoding (IDLE -> RUN -> DONE)
//  - clog2   : ceiling log2, used to size the digit counter
package serial_arith_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Smallest r with (1 << r) >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((32'sd1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder, the single arithmetic slice shared
// by every cycle of the serial operation.
// Ports:
//  a, b      in  DIGIT  addend digits
//  ci        in  1      carry in
//  s         out DIGIT  sum digit
//  co        out 1      carry out of the MSB
//  c_msb_in  out 1      carry into the MSB (signed-overflow detection)
module digit_adder
  import serial_arith_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [DIGIT:0] full;

  // The adder chain; written as one addition so the carry vector does not
  // feed back on itself as a combinational loop in simulation.
  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, ci};
  end

  assign s        = full[DIGIT-1:0];
  assign co       = full[DIGIT];
  // The MSB full adder computes s = a ^ b ^ cin, so cin is recovered here.
  assign c_msb_in = a[DIGIT-1] ^ b[DIGIT-1] ^ full[DIGIT-1];

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor. DIGIT bits of the WIDTH-bit operands are
// added per clock through one shared digit_adder; a full operation takes
// WIDTH/DIGIT RUN cycles followed by a one-cycle done pulse.
// Ports:
//  clk    in   1      rising-edge clock
//  rst_n  in   1      asynchronous active-low reset
//  start  in   1      request, honoured only when not busy
//  sub    in   1      0: a+b+cin, 1: a-b-cin
//  a, b   in   WIDTH  operands, captured on accepted start
//  cin    in   1      carry-in (borrow-in when sub=1)
//  busy   out  1      operation in progress
//  done   out  1      one-cycle pulse, result valid
//  sum    out  WIDTH  result, held until the next accepted start
//  cout   out  1      carry out (add) / borrow out (sub)
//  ovf    out  1      signed overflow of the full-width result
module serial_add_sub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (clog2(NDIG) < 1) ? 1 : clog2(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  generate
    if ((WIDTH % DIGIT) != 0) begin : g_param_check
      $error("serial_add_sub: WIDTH (%0d) must be a multiple of DIGIT (%0d)", WIDTH, DIGIT);
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] a_sh;      // captured A, shifted right one digit per cycle
  logic [WIDTH-1:0] b_sh;      // captured B (inverted for subtract), shifted likewise
  logic             carry;
  logic             sub_q;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] dsum;
  logic             dco;
  logic             dcm;
  logic [WIDTH-1:0] sum_next;

  // The low digit of each shift register is always the digit being processed.
  digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit (
    .a        (a_sh[DIGIT-1:0]),
    .b        (b_sh[DIGIT-1:0]),
    .ci       (carry),
    .s        (dsum),
    .co       (dco),
    .c_msb_in (dcm)
  );

  // Result with the current digit slot overwritten in place by the new digit.
  always_comb begin
    sum_next = sum;
    for (int k = 0; k < NDIG; k++) begin
      if (cnt == CW'(k)) begin
        sum_next[k*DIGIT +: DIGIT] = dsum;
      end else begin
        sum_next[k*DIGIT +: DIGIT] = sum[k*DIGIT +: DIGIT];
      end
    end
  end

  // Control FSM, operand/carry datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      sub_q <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // The done pulse lasts exactly one cycle even if a new op starts now.
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + ~cin: invert B and the incoming borrow.
            a_sh  <= a;
            b_sh  <= b ^ {WIDTH{sub}};
            carry <= cin ^ sub;
            sub_q <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          sum   <= sum_next;
          carry <= dco;
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            // A carry out of the inverted-B sum means "no borrow".
            cout  <= dco ^ sub_q;
            // Sign-bit carry in/out disagreement is two's-complement overflow.
            ovf   <= dco ^ dcm;
            state <= S_DONE;
          end else begin
            state <= S_RUN;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
